// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-requester ALU arbiter: FSM state encoding,
// the eight opcode values forwarded to the external ALU, and the default
// operand MSB index.
package alu_arbiter_pkg;

    // Default MSB index of an operand word (operands are DEF_NBITS+1 bits).
    localparam int DEF_NBITS = 15;

    // Arbiter FSM states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Opcodes are opaque to the arbiter and forwarded unmodified.
    localparam logic [2:0] OP_0 = 3'd0;
    localparam logic [2:0] OP_1 = 3'd1;
    localparam logic [2:0] OP_2 = 3'd2;
    localparam logic [2:0] OP_3 = 3'd3;
    localparam logic [2:0] OP_4 = 3'd4;
    localparam logic [2:0] OP_5 = 3'd5;
    localparam logic [2:0] OP_6 = 3'd6;
    localparam logic [2:0] OP_7 = 3'd7;

endpackage

// File: rtl/alu_arbiter_rr_pick.sv
// Two-way priority pick: a lone valid requester always wins; when both are
// valid the priority pointer names the winner.
module rr_pick
    import alu_arbiter_pkg::*;
(
    input  logic valid0_i,
    input  logic valid1_i,
    input  logic ptr_i,
    output logic gnt_id_o,
    output logic any_o
);

    // Select the winner from the two valids and the pointer.
    always_comb begin
        any_o    = valid0_i | valid1_i;
        gnt_id_o = (valid0_i & valid1_i) ? ptr_i : valid1_i;
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external ALU between two requesters. One operation is in
// flight at a time: IDLE grants a requester and latches its operands, EXEC
// drives the ALU for ALU_LAT+1 cycles and captures the result, RESP holds
// the result until the owning requester takes it.
//
// Handshakes: a request transfers in a cycle where reqN_valid and
// reqN_ready are both high (ready is combinational and only ever high in
// IDLE); a response transfers in a cycle where rspN_valid and rspN_ready
// are both high, and rsp_y/rsp_co hold steady until that cycle.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int          NBITS       = DEF_NBITS,
    parameter int          ALU_LAT     = 1,        // legal range 0..3
    parameter logic [15:0] CNT_PRELOAD = 16'h0000  // op_count value after reset
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [NBITS:0]   req0_a,
    input  logic [NBITS:0]   req0_b,
    input  logic [2:0]       req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [NBITS:0]   req1_a,
    input  logic [NBITS:0]   req1_b,
    input  logic [2:0]       req1_op,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [NBITS+1:0] rsp_y,
    output logic             rsp_co,
    output logic [NBITS:0]   alu_a,
    output logic [NBITS:0]   alu_b,
    output logic [2:0]       alu_op,
    input  logic [NBITS+1:0] alu_y,
    input  logic             alu_co,
    output logic             busy,
    output logic [15:0]      op_count,
    output logic [1:0]       state_dbg
);

    localparam logic [1:0] LAT_INIT = ALU_LAT[1:0];

    state_e           state_q, state_d;
    logic [1:0]       cnt_q, cnt_d;
    logic             owner_q, owner_d;
    logic             ptr_q, ptr_d;
    logic [NBITS:0]   a_q, a_d;
    logic [NBITS:0]   b_q, b_d;
    logic [2:0]       op_q, op_d;
    logic [NBITS+1:0] y_q, y_d;
    logic             co_q, co_d;
    logic [15:0]      op_count_q, op_count_d;

    logic gnt_id;
    logic any_req;
    logic rsp_done;

    rr_pick u_rr_pick (
        .valid0_i (req0_valid),
        .valid1_i (req1_valid),
        .ptr_i    (ptr_q),
        .gnt_id_o (gnt_id),
        .any_o    (any_req)
    );

    // The owner's response handshake completes this cycle.
    assign rsp_done = owner_q ? rsp1_ready : rsp0_ready;

    // Next-state and output decode; everything defaults to hold / zero.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        owner_d    = owner_q;
        ptr_d      = ptr_q;
        a_d        = a_q;
        b_d        = b_q;
        op_d       = op_q;
        y_d        = y_q;
        co_d       = co_q;
        op_count_d = op_count_q;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp0_valid = 1'b0;
        rsp1_valid = 1'b0;
        alu_a      = '0;
        alu_b      = '0;
        alu_op     = '0;
        case (state_q)
            ST_IDLE: begin
                // Ready is combinational, so it is also gated by reset to
                // stay low while arst_n is asserted.
                if (any_req && arst_n) begin
                    req0_ready = ~gnt_id;
                    req1_ready = gnt_id;
                    owner_d    = gnt_id;
                    a_d        = gnt_id ? req1_a  : req0_a;
                    b_d        = gnt_id ? req1_b  : req0_b;
                    op_d       = gnt_id ? req1_op : req0_op;
                    cnt_d      = LAT_INIT;
                    state_d    = ST_EXEC;
                end
            end
            ST_EXEC: begin
                alu_a  = a_q;
                alu_b  = b_q;
                alu_op = op_q;
                if (cnt_q == 2'd0) begin
                    y_d     = alu_y;
                    co_d    = alu_co;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            ST_RESP: begin
                rsp0_valid = ~owner_q;
                rsp1_valid = owner_q;
                if (rsp_done) begin
                    state_d = ST_IDLE;
                    ptr_d   = ~owner_q;
                    if (op_count_q != 16'hFFFF) begin
                        op_count_d = op_count_q + 16'd1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any pending operation.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 2'd0;
            owner_q    <= 1'b0;
            ptr_q      <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= 3'd0;
            y_q        <= '0;
            co_q       <= 1'b0;
            op_count_q <= CNT_PRELOAD;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            owner_q    <= owner_d;
            ptr_q      <= ptr_d;
            a_q        <= a_d;
            b_q        <= b_d;
            op_q       <= op_d;
            y_q        <= y_d;
            co_q       <= co_d;
            op_count_q <= op_count_d;
        end
    end

    assign rsp_y     = y_q;
    assign rsp_co    = co_q;
    assign busy      = (state_q != ST_IDLE);
    assign op_count  = op_count_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: three instances (ALU latency 1, 0 and 3), each fed
// by a bench ALU whose result appears exactly ALU_LAT cycles after its
// operands. Directed table vectors, hand-written arbitration/reset/saturation
// sequences, and a randomized run against a transaction-level model.
module tb_alu_arbiter;
    import alu_arbiter_pkg::*;

    localparam int NB = 15;
    localparam int NI = 3;

    logic clk;
    logic arst_n;

    logic          req0_valid [NI];
    logic          req1_valid [NI];
    logic          req0_ready [NI];
    logic          req1_ready [NI];
    logic [NB:0]   req0_a     [NI];
    logic [NB:0]   req0_b     [NI];
    logic [NB:0]   req1_a     [NI];
    logic [NB:0]   req1_b     [NI];
    logic [2:0]    req0_op    [NI];
    logic [2:0]    req1_op    [NI];
    logic          rsp0_valid [NI];
    logic          rsp1_valid [NI];
    logic          rsp0_ready [NI];
    logic          rsp1_ready [NI];
    logic [NB+1:0] rsp_y      [NI];
    logic          rsp_co     [NI];
    logic [NB:0]   alu_a      [NI];
    logic [NB:0]   alu_b      [NI];
    logic [2:0]    alu_op     [NI];
    logic          busy       [NI];
    logic [15:0]   op_count   [NI];
    logic [1:0]    state_dbg  [NI];

    int checks = 0;
    int errors = 0;

    // Bench ALU: {co, y}. Arithmetic on zero-extended operands, carry/borrow
    // is bit 16 of the 17-bit result; logic ops give carry 0.
    function automatic logic [17:0] alu_f(input logic [15:0] a, input logic [15:0] b,
                                          input logic [2:0] op);
        logic [16:0] r;
        logic        co;
        r  = '0;
        co = 1'b0;
        case (op)
            3'd0: begin r = {1'b0, a} + {1'b0, b}; co = r[16]; end
            3'd1: begin r = {1'b0, a} - {1'b0, b}; co = r[16]; end
            3'd2: r = {1'b0, a & b};
            3'd3: r = {1'b0, a | b};
            3'd4: r = {1'b0, a ^ b};
            3'd5: begin r = {1'b0, a} + 17'd1; co = r[16]; end
            3'd6: begin r = {1'b0, a} - 17'd1; co = r[16]; end
            default: r = {1'b0, a};
        endcase
        return {co, r};
    endfunction

    // Clock generation.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar k = 0; k < NI; k++) begin : g_inst
        localparam int          LAT = (k == 0) ? 1 : ((k == 1) ? 0 : 3);
        localparam logic [15:0] PRE = (k == 1) ? 16'hFFFC : 16'h0000;
        logic [17:0] p0, p1, p2, res;

        // Pipelined bench ALU.
        always @(posedge clk) begin
            p0 <= alu_f(alu_a[k], alu_b[k], alu_op[k]);
            p1 <= p0;
            p2 <= p1;
        end

        // Tap the pipeline at this instance's latency.
        always_comb begin
            res = alu_f(alu_a[k], alu_b[k], alu_op[k]);
            if (LAT == 1) res = p0;
            else if (LAT == 2) res = p1;
            else if (LAT == 3) res = p2;
        end

        alu_arbiter #(.NBITS(NB), .ALU_LAT(LAT), .CNT_PRELOAD(PRE)) u_dut (
            .clk        (clk),
            .arst_n     (arst_n),
            .req0_valid (req0_valid[k]),
            .req0_ready (req0_ready[k]),
            .req0_a     (req0_a[k]),
            .req0_b     (req0_b[k]),
            .req0_op    (req0_op[k]),
            .req1_valid (req1_valid[k]),
            .req1_ready (req1_ready[k]),
            .req1_a     (req1_a[k]),
            .req1_b     (req1_b[k]),
            .req1_op    (req1_op[k]),
            .rsp0_valid (rsp0_valid[k]),
            .rsp0_ready (rsp0_ready[k]),
            .rsp1_valid (rsp1_valid[k]),
            .rsp1_ready (rsp1_ready[k]),
            .rsp_y      (rsp_y[k]),
            .rsp_co     (rsp_co[k]),
            .alu_a      (alu_a[k]),
            .alu_b      (alu_b[k]),
            .alu_op     (alu_op[k]),
            .alu_y      (res[16:0]),
            .alu_co     (res[17]),
            .busy       (busy[k]),
            .op_count   (op_count[k]),
            .state_dbg  (state_dbg[k])
        );
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive_req(input int k, input logic id, input logic v, input logic [2:0] op,
                             input logic [15:0] a, input logic [15:0] b);
        if (id == 1'b0) begin
            req0_valid[k] = v; req0_op[k] = op; req0_a[k] = a; req0_b[k] = b;
        end else begin
            req1_valid[k] = v; req1_op[k] = op; req1_a[k] = a; req1_b[k] = b;
        end
    endtask

    task automatic set_valid(input int k, input logic id, input logic v);
        if (id == 1'b0) req0_valid[k] = v;
        else            req1_valid[k] = v;
    endtask

    task automatic set_rsp_ready(input int k, input logic id, input logic v);
        if (id == 1'b0) rsp0_ready[k] = v;
        else            rsp1_ready[k] = v;
    endtask

    function automatic logic get_ready(input int k, input logic id);
        return id ? req1_ready[k] : req0_ready[k];
    endfunction

    function automatic logic get_rv(input int k, input logic id);
        return id ? rsp1_valid[k] : rsp0_valid[k];
    endfunction

    // Check every output of instance 0 is at its reset value.
    task automatic chk_zero(input string name);
        chk({name, "_rdy0"}, 32'(req0_ready[0]), 0);
        chk({name, "_rdy1"}, 32'(req1_ready[0]), 0);
        chk({name, "_rv0"},  32'(rsp0_valid[0]), 0);
        chk({name, "_rv1"},  32'(rsp1_valid[0]), 0);
        chk({name, "_y"},    32'(rsp_y[0]), 0);
        chk({name, "_co"},   32'(rsp_co[0]), 0);
        chk({name, "_alu"},  {alu_op[0], alu_a[0] | alu_b[0]}, 0);
        chk({name, "_busy"}, 32'(busy[0]), 0);
        chk({name, "_cnt"},  32'(op_count[0]), 0);
        chk({name, "_st"},   32'(state_dbg[0]), 32'(ST_IDLE));
    endtask

    // Reset with both instance-0 requesters valid, so the combinational
    // ready is exercised under reset. Ends one tick after the first edge
    // with arst_n high.
    task automatic do_reset(input string name);
        @(negedge clk);
        arst_n = 1'b0;
        req0_valid[0] = 1'b1;
        req1_valid[0] = 1'b1;
        #1;
        chk_zero(name);
        for (int k = 0; k < NI; k++) begin
            req0_valid[k] = 1'b0; req1_valid[k] = 1'b0;
            rsp0_ready[k] = 1'b0; rsp1_ready[k] = 1'b0;
        end
        @(negedge clk);
        arst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Inputs for the grant cycle are already driven; check the grant, then
    // move into the next cycle with the winner's valid dropped.
    task automatic grant_cycle(input int k, input logic exp_id, input string name);
        @(negedge clk);
        chk({name, "_rdy_win"},  32'(get_ready(k, exp_id)), 1);
        chk({name, "_rdy_lose"}, 32'(get_ready(k, ~exp_id)), 0);
        chk({name, "_busy_g"},   32'(busy[k]), 0);
        @(posedge clk);
        #1;
        set_valid(k, exp_id, 1'b0);
    endtask

    // Called one tick into cycle T+1. Measures response latency, checks the
    // ALU drive while executing, holds rsp_ready low for `hold` cycles, then
    // completes the handshake. Returns one tick into the following cycle.
    task automatic wait_resp(input int k, input logic id, input int lat, input logic [15:0] a,
                             input logic [15:0] b, input logic [2:0] op,
                             input logic [17:0] exp_res, input int hold, input string name);
        int n;
        bit seen;
        n = 1;
        seen = 0;
        while (n <= 8) begin
            @(negedge clk);
            if (get_rv(k, id)) begin
                seen = 1;
                break;
            end
            chk({name, "_alu_exec"}, {alu_op[k], alu_a[k], alu_b[k]}, {op, a, b});
            chk({name, "_rdy_exec"}, {30'd0, req0_ready[k], req1_ready[k]}, 0);
            @(posedge clk);
            #1;
            n++;
        end
        chk({name, "_latency"}, seen ? n : 99, 2 + lat);
        if (seen) begin
            chk({name, "_y"},        32'(rsp_y[k]), 32'(exp_res[16:0]));
            chk({name, "_co"},       32'(rsp_co[k]), 32'(exp_res[17]));
            chk({name, "_rv_other"}, 32'(get_rv(k, ~id)), 0);
            chk({name, "_alu_resp"}, {alu_op[k], alu_a[k] | alu_b[k]}, 0);
            chk({name, "_busy"},     32'(busy[k]), 1);
            for (int h = 0; h < hold; h++) begin
                @(posedge clk);
                #1;
                @(negedge clk);
                chk({name, "_hold_rv"},  32'(get_rv(k, id)), 1);
                chk({name, "_hold_y"},   {14'd0, rsp_co[k], rsp_y[k]}, 32'(exp_res));
                chk({name, "_hold_rdy"}, {30'd0, req0_ready[k], req1_ready[k]}, 0);
            end
            set_rsp_ready(k, id, 1'b1);
            #1;
            chk({name, "_rdy_done"}, {30'd0, req0_ready[k], req1_ready[k]}, 0);
            @(posedge clk);
            #1;
            set_rsp_ready(k, id, 1'b0);
        end
    endtask

    typedef struct {
        logic        id;
        logic [2:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [16:0] y;
        logic        co;
        int          hold;
    } vec_t;

    vec_t tab [12];

    // Bounded overall run time.
    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

    initial begin
        tab[0]  = '{1'b0, 3'd0, 16'd5,     16'd3,     17'h00008, 1'b0, 0};
        tab[1]  = '{1'b1, 3'd1, 16'd5,     16'd3,     17'h00002, 1'b0, 1};
        tab[2]  = '{1'b0, 3'd1, 16'd3,     16'd5,     17'h1FFFE, 1'b1, 0};
        tab[3]  = '{1'b1, 3'd2, 16'hF0F0,  16'hFF00,  17'h0F000, 1'b0, 2};
        tab[4]  = '{1'b0, 3'd3, 16'h00F0,  16'h0F00,  17'h00FF0, 1'b0, 0};
        tab[5]  = '{1'b1, 3'd4, 16'hFFFF,  16'h00FF,  17'h0FF00, 1'b0, 1};
        tab[6]  = '{1'b0, 3'd5, 16'd7,     16'd0,     17'h00008, 1'b0, 0};
        tab[7]  = '{1'b1, 3'd6, 16'd7,     16'd0,     17'h00006, 1'b0, 0};
        tab[8]  = '{1'b0, 3'd6, 16'd0,     16'd0,     17'h1FFFF, 1'b1, 2};
        tab[9]  = '{1'b1, 3'd7, 16'h1234,  16'h9999,  17'h01234, 1'b0, 0};
        tab[10] = '{1'b0, 3'd0, 16'hFFFF,  16'h0001,  17'h10000, 1'b1, 0};
        tab[11] = '{1'b1, 3'd5, 16'hFFFF,  16'h0000,  17'h10000, 1'b1, 1};

        arst_n = 1'b0;
        for (int k = 0; k < NI; k++) begin
            drive_req(k, 1'b0, 1'b0, 3'd0, 16'd0, 16'd0);
            drive_req(k, 1'b1, 1'b0, 3'd0, 16'd0, 16'd0);
            rsp0_ready[k] = 1'b0;
            rsp1_ready[k] = 1'b0;
        end

        // Directed single-requester vectors.
        do_reset("rst0");
        for (int i = 0; i < 12; i++) begin
            drive_req(0, tab[i].id, 1'b1, tab[i].op, tab[i].a, tab[i].b);
            grant_cycle(0, tab[i].id, $sformatf("vec%0d", i));
            wait_resp(0, tab[i].id, 1, tab[i].a, tab[i].b, tab[i].op,
                      {tab[i].co, tab[i].y}, tab[i].hold, $sformatf("vec%0d", i));
            @(negedge clk);
            chk($sformatf("vec%0d_cnt", i), 32'(op_count[0]), i + 1);
            @(posedge clk);
            #1;
        end

        // Contention: pointer starts at req0 after reset, then alternates.
        do_reset("rst1");
        drive_req(0, 1'b0, 1'b1, 3'd5, 16'd7, 16'd0);
        drive_req(0, 1'b1, 1'b1, 3'd6, 16'd7, 16'd0);
        grant_cycle(0, 1'b0, "arb_a");
        wait_resp(0, 1'b0, 1, 16'd7, 16'd0, 3'd5, 18'h00008, 0, "arb_a");
        drive_req(0, 1'b0, 1'b1, 3'd7, 16'h0055, 16'd0);
        grant_cycle(0, 1'b1, "arb_b");
        wait_resp(0, 1'b1, 1, 16'd7, 16'd0, 3'd6, 18'h00006, 0, "arb_b");
        drive_req(0, 1'b1, 1'b1, 3'd4, 16'h00F0, 16'h000F);
        grant_cycle(0, 1'b0, "arb_c");
        set_valid(0, 1'b1, 1'b0);
        wait_resp(0, 1'b0, 1, 16'h0055, 16'd0, 3'd7, 18'h00055, 0, "arb_c");

        // Response back-pressure with req1 waiting; req1 wins the next cycle.
        drive_req(0, 1'b0, 1'b1, 3'd3, 16'h0A00, 16'h00A0);
        grant_cycle(0, 1'b0, "bp0");
        drive_req(0, 1'b1, 1'b1, 3'd4, 16'hAAAA, 16'h5555);
        wait_resp(0, 1'b0, 1, 16'h0A00, 16'h00A0, 3'd3, 18'h00AA0, 4, "bp0");
        grant_cycle(0, 1'b1, "bp1");
        wait_resp(0, 1'b1, 1, 16'hAAAA, 16'h5555, 3'd4, 18'h0FFFF, 0, "bp1");
        @(negedge clk);
        chk("arb_bp_cnt", 32'(op_count[0]), 5);
        @(posedge clk);
        #1;

        // Reset during EXEC discards the operation.
        drive_req(0, 1'b0, 1'b1, 3'd0, 16'd9, 16'd9);
        grant_cycle(0, 1'b0, "rexec");
        #1;
        arst_n = 1'b0;
        #1;
        chk_zero("rexec");
        @(negedge clk);
        arst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk("rexec_no_rsp", {30'd0, rsp0_valid[0], rsp1_valid[0]}, 0);
            chk("rexec_cnt", 32'(op_count[0]), 0);
        end
        @(posedge clk);
        #1;

        // Latency 0 and 3 instances with a carry-producing add.
        drive_req(1, 1'b0, 1'b1, 3'd0, 16'hFFFF, 16'h0001);
        grant_cycle(1, 1'b0, "lat0");
        wait_resp(1, 1'b0, 0, 16'hFFFF, 16'h0001, 3'd0, alu_f(16'hFFFF, 16'h0001, 3'd0), 0, "lat0");
        drive_req(2, 1'b0, 1'b1, 3'd0, 16'hFFFF, 16'h0001);
        grant_cycle(2, 1'b0, "lat3");
        wait_resp(2, 1'b0, 3, 16'hFFFF, 16'h0001, 3'd0, alu_f(16'hFFFF, 16'h0001, 3'd0), 1, "lat3");

        // Saturation on the preloaded latency-0 instance.
        do_reset("rst2");
        @(negedge clk);
        chk("sat_preload", 32'(op_count[1]), 32'h0000FFFC);
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            logic [15:0] a;
            logic [15:0] b;
            logic [2:0]  op;
            int          expc;
            a  = 16'($urandom);
            b  = 16'($urandom);
            op = 3'($urandom_range(0, 7));
            drive_req(1, 1'(i % 2), 1'b1, op, a, b);
            grant_cycle(1, 1'(i % 2), "sat");
            wait_resp(1, 1'(i % 2), 0, a, b, op, alu_f(a, b, op), 0, "sat");
            expc = (32'hFFFC + i + 1 > 32'hFFFF) ? 32'hFFFF : 32'hFFFC + i + 1;
            @(negedge clk);
            chk($sformatf("sat_cnt%0d", i), 32'(op_count[1]), expc);
            @(posedge clk);
            #1;
        end

        // Randomized traffic on instance 0 against a transaction model.
        do_reset("rst3");
        begin : rnd
            logic        pend;
            logic        own;
            int          tstart;
            logic        ptr;
            logic [15:0] cnt;
            logic [17:0] exp_q [$];
            logic        v0, v1, r0, r1, grant, gid, e_rv0, e_rv1;
            logic [2:0]  o0, o1;
            logic [15:0] a0, b0, a1, b1;
            pend = 1'b0;
            own = 1'b0;
            tstart = 0;
            ptr = 1'b0;
            cnt = 16'd0;
            for (int cyc = 0; cyc < 600; cyc++) begin
                v0 = ($urandom_range(0, 2) != 0);
                v1 = ($urandom_range(0, 2) != 0);
                o0 = 3'($urandom_range(0, 7));
                o1 = 3'($urandom_range(0, 7));
                a0 = 16'($urandom); b0 = 16'($urandom);
                a1 = 16'($urandom); b1 = 16'($urandom);
                r0 = ($urandom_range(0, 2) == 0);
                r1 = ($urandom_range(0, 2) == 0);
                drive_req(0, 1'b0, v0, o0, a0, b0);
                drive_req(0, 1'b1, v1, o1, a1, b1);
                rsp0_ready[0] = r0;
                rsp1_ready[0] = r1;
                grant = !pend && (v0 || v1);
                gid   = (v0 && v1) ? ptr : v1;
                e_rv0 = pend && !own && (cyc >= tstart + 3);
                e_rv1 = pend && own && (cyc >= tstart + 3);
                @(negedge clk);
                chk("rnd_rdy0", 32'(req0_ready[0]), 32'(grant && !gid));
                chk("rnd_rdy1", 32'(req1_ready[0]), 32'(grant && gid));
                chk("rnd_rv0",  32'(rsp0_valid[0]), 32'(e_rv0));
                chk("rnd_rv1",  32'(rsp1_valid[0]), 32'(e_rv1));
                chk("rnd_busy", 32'(busy[0]), 32'(pend));
                chk("rnd_cnt",  32'(op_count[0]), 32'(cnt));
                if ((e_rv0 || e_rv1) && exp_q.size() > 0) begin
                    chk("rnd_res", {14'd0, rsp_co[0], rsp_y[0]}, 32'(exp_q[0]));
                end
                if (grant) begin
                    pend   = 1'b1;
                    own    = gid;
                    tstart = cyc;
                    exp_q.push_back(gid ? alu_f(a1, b1, o1) : alu_f(a0, b0, o0));
                end else if ((e_rv0 && r0) || (e_rv1 && r1)) begin
                    pend = 1'b0;
                    ptr  = !own;
                    if (cnt != 16'hFFFF) cnt = cnt + 16'd1;
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                end
                @(posedge clk);
                #1;
            end
        end

        for (int k = 0; k < NI; k++) begin
            req0_valid[k] = 1'b0; req1_valid[k] = 1'b0;
            rsp0_ready[k] = 1'b0; rsp1_ready[k] = 1'b0;
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter NBITS, default 15, MSB index of operand words (operands NBITS+1 bits wide).
REQ-002 Parameter ALU_LAT, default 1, ALU result latency in clk cycles after operands are presented; legal range 0..3.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 arst_n  input  1  reset, asynchronous and active-low.
REQ-005 reqN_valid  input  1  (N=0,1) requester N presents an operation.
REQ-006 reqN_ready  output  1  (N=0,1) operation from requester N accepted this cycle.
REQ-007 reqN_a, reqN_b  input  NBITS+1  (N=0,1) signed operands.
REQ-008 reqN_op  input  3  (N=0,1) ALU opcode, all 8 codes legal, passed unmodified.
REQ-009 rspN_valid  output  1  (N=0,1) result for requester N available.
REQ-010 rspN_ready  input  1  (N=0,1) requester N consumes result.
REQ-011 rsp_y  output  NBITS+2  result word, shared by both response ports.
REQ-012 rsp_co  output  1  carry-out, shared.
REQ-013 alu_a, alu_b  output  NBITS+1  operands to shared ALU.
REQ-014 alu_op  output  3  opcode to shared ALU.
REQ-015 alu_y  input  NBITS+2  ALU result.
REQ-016 alu_co  input  1  ALU carry-out.
REQ-017 busy  output  1  high in any state other than IDLE.
REQ-018 op_count  output  16  number of completed operations, saturating.

Function
REQ-019 FSM states SHALL be IDLE, EXEC, RESP; one operation outstanding at a time.
REQ-020 IDLE: if any reqN_valid, grant one requester, assert its reqN_ready combinationally that cycle, latch a/b/op and owner id, load latency counter with ALU_LAT, go EXEC.
REQ-021 Grant: only one valid -> that one; both valid -> requester selected by priority pointer.
REQ-022 reqN_ready SHALL be low in EXEC and RESP and for the non-granted requester.
REQ-023 EXEC: alu_a/alu_b/alu_op driven from latched registers; counter decrements each cycle; in the cycle counter==0, alu_y/alu_co captured into rsp_y/rsp_co, go RESP.
REQ-024 alu_a/alu_b/alu_op SHALL be zero in IDLE and RESP.
REQ-025 Latency: handshake in cycle T -> rsp_owner_valid first high in cycle T+2+ALU_LAT.
REQ-026 RESP: rspN_valid high only for owner; rsp_y/rsp_co stable until rspN_ready sampled high; then go IDLE, pointer set to the non-owner, op_count incremented.
REQ-027 New requests SHALL NOT be accepted in the cycle rspN_ready completes; earliest next accept is the following IDLE cycle.
REQ-028 op_count SHALL saturate at 0xFFFF (no wrap).
REQ-029 reqN_valid dropping while not granted SHALL have no effect; no request is stored without a handshake.

Reset
REQ-030 arst_n low SHALL immediately force: state IDLE, all reqN_ready/rspN_valid 0, rsp_y 0, rsp_co 0, alu_* 0, busy 0, op_count 0, priority pointer 0.
REQ-031 Reset during EXEC or RESP SHALL discard the pending operation; no response is produced after release.
REQ-032 First possible grant is the first rising edge with arst_n high.

Structure
REQ-033 Shared package SHALL hold state encoding (IDLE/EXEC/RESP), opcode constants (3'd0..3'd7) and default NBITS.
REQ-034 One sub-module, rr_pick, SHALL implement the 2-way priority selection (inputs: two valids, pointer; outputs: grant id, any).
REQ-035 The ALU itself is external; the block SHALL NOT contain arithmetic beyond the latency counter and op_count.

Verification
REQ-036 ALU_LAT=1, req0 op=0 A=5 B=3 at T -> req0_ready high at T, rsp0_valid at T+3, rsp_y=8, rsp_co=0, op_count=1.
REQ-037 Both valid after reset (req0 op=5 A=7, req1 op=6 A=7) -> req0 served first (y=8), then req1 (y=6); next both-valid contest goes to req0 again only after req1 served.
REQ-038 rsp0_ready held low 4 cycles in RESP -> rsp0_valid and rsp_y stable throughout, req1_ready stays low, req1 granted one cycle after rsp0 handshake.
REQ-039 arst_n pulsed low during EXEC -> all outputs zero immediately, no rspN_valid ever for that operation, op_count 0.
REQ-040 ALU_LAT=0 and ALU_LAT=3, op=0 A=0xFFFF B=0x0001 with bench ALU model -> rsp_valid at T+2 and T+5 respectively, rsp_y/rsp_co equal model output.
REQ-041 Force op_count to 0xFFFE via 2 completions from preload, then 3 more completions -> op_count holds 0xFFFF.
